// File: rtl/uart_fifo_if.sv
// CPU-side bus of uart_fifo: control word, TX push, RX pop, sticky-flag clear, status and interrupt.
interface uart_fifo_if;
    logic [31:0] ctrl;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        clear_flags;
    logic [31:0] status;
    logic        irq;

    modport master (output ctrl, tx_data, tx_wr, rx_rd, clear_flags,
                    input  rx_data, status, irq);
    modport slave  (input  ctrl, tx_data, tx_wr, rx_rd, clear_flags,
                    output rx_data, status, irq);
endinterface

// File: rtl/uart_fifo.sv
// Full-duplex UART with TX/RX FIFOs, runtime frame format, sticky error flags and level irq.
// Parity support is compiled in only when UART_PARITY_EN is defined.
module uart_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_fifo_if.slave bus,
    input  logic       pin_rx_i,
    output logic       pin_tx_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
        TX_PARITY = 3'd3, TX_STOP1 = 3'd4, TX_STOP2 = 3'd5
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
        RX_PARITY = 3'd3, RX_STOP = 3'd4, RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic logic parity8(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic [DIV_W-1:0] cfg_div_s;
    logic             cfg_pen_s, cfg_odd_s, cfg_two_s;
    logic             par_set_s;
    logic             unused_s;

    // TX FIFO
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_push_s, tx_pop_s;

    // RX FIFO
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q;
    logic [CW-1:0] rx_cnt_q;
    logic          rx_pop_s, rx_wr_s;

    // TX FSM
    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_baud_q, tx_baud_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_pen_q, tx_pen_d, tx_odd_q, tx_odd_d, tx_two_q, tx_two_d;
    logic             pin_tx_q, pin_tx_d, tx_end_s;

    // RX FSM
    logic [2:0]       rx_sync_q;
    logic             rx_prev_q, rx_s;
    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_baud_q, rx_baud_d, rx_div_q, rx_div_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
    logic             rx_par_bad_q, rx_par_bad_d, rx_push_q, rx_push_d;
    logic             ferr_set_s, ovf_set_s;

    // Flags and registered outputs
    logic        ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [31:0] status_q, status_d;
    logic        irq_q, irq_d;
    logic        tx_busy_s, tx_empty_s, rx_avail_s;

    assign cfg_div_s = (bus.ctrl[DIV_W-1:0] < DIV_W'(3)) ? DIV_W'(3) : bus.ctrl[DIV_W-1:0];
    assign cfg_two_s = bus.ctrl[18];
`ifdef UART_PARITY_EN
    assign cfg_pen_s = bus.ctrl[16];
    assign cfg_odd_s = bus.ctrl[17];
    assign par_set_s = rx_wr_s && rx_par_bad_q;
    assign unused_s  = ^bus.ctrl[31:21];
`else
    assign cfg_pen_s = 1'b0;
    assign cfg_odd_s = 1'b0;
    assign par_set_s = 1'b0;
    assign unused_s  = ^{bus.ctrl[31:21], bus.ctrl[17:16], rx_par_bad_q};
`endif

    assign tx_push_s = bus.tx_wr && (tx_cnt_q != FULL_C);
    // A pop frees a slot in the same cycle, so a push into a full RX FIFO still lands.
    assign rx_pop_s  = bus.rx_rd && (rx_cnt_q != CW'(0));
    assign rx_wr_s   = rx_push_q && ((rx_cnt_q != FULL_C) || rx_pop_s);
    assign ovf_set_s = rx_push_q && !rx_wr_s;
    assign rx_s      = rx_sync_q[2];

    assign bus.rx_data = (rx_cnt_q != CW'(0)) ? rx_mem_q[rx_rp_q] : 8'd0;
    assign bus.status  = status_q;
    assign bus.irq     = irq_q;
    assign pin_tx_o    = pin_tx_q;

    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wp_q] <= bus.tx_data;
        end
        if (rx_wr_s) begin
            rx_mem_q[rx_wp_q] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_wp_q  <= tx_wp_q + AW'(tx_push_s);
            tx_rp_q  <= tx_rp_q + AW'(tx_pop_s);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push_s) - CW'(tx_pop_s);
            rx_wp_q  <= rx_wp_q + AW'(rx_wr_s);
            rx_rp_q  <= rx_rp_q + AW'(rx_pop_s);
            rx_cnt_q <= rx_cnt_q + CW'(rx_wr_s) - CW'(rx_pop_s);
        end
    end

    // TX next state: pin_tx is registered from the next state so each bit lasts exactly div+1 clocks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q + DIV_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_div_d   = tx_div_q;
        tx_pen_d   = tx_pen_q;
        tx_odd_d   = tx_odd_q;
        tx_two_d   = tx_two_q;
        pin_tx_d   = pin_tx_q;
        tx_pop_s   = 1'b0;
        tx_end_s   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                pin_tx_d = 1'b1;
            end
            TX_START: begin
                if (tx_baud_q == tx_div_q) begin
                    tx_state_d = TX_DATA;
                    tx_baud_d  = DIV_W'(0);
                    tx_bit_d   = 3'd0;
                    pin_tx_d   = tx_byte_q[0];
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_baud_q == tx_div_q) begin
                    tx_baud_d = DIV_W'(0);
                    if (tx_bit_q == 3'd7) begin
                        if (tx_pen_q) begin
                            tx_state_d = TX_PARITY;
                            pin_tx_d   = parity8(tx_byte_q, tx_odd_q);
                        end else begin
                            tx_state_d = TX_STOP1;
                            pin_tx_d   = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        pin_tx_d = tx_byte_q[tx_bit_q + 3'd1];
                    end
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_baud_q == tx_div_q) begin
                    tx_state_d = TX_STOP1;
                    tx_baud_d  = DIV_W'(0);
                    pin_tx_d   = 1'b1;
                end else begin
                    tx_state_d = TX_PARITY;
                end
            end
            TX_STOP1: begin
                if ((tx_baud_q == tx_div_q) && tx_two_q) begin
                    tx_state_d = TX_STOP2;
                    tx_baud_d  = DIV_W'(0);
                end else begin
                    tx_end_s = (tx_baud_q == tx_div_q);
                end
            end
            TX_STOP2: begin
                tx_end_s = (tx_baud_q == tx_div_q);
            end
            default: begin
                tx_state_d = TX_IDLE;
                pin_tx_d   = 1'b1;
            end
        endcase
        if ((tx_state_q == TX_IDLE) || tx_end_s) begin
            tx_baud_d = DIV_W'(0);
            if (tx_cnt_q != CW'(0)) begin
                tx_state_d = TX_START;
                tx_pop_s   = 1'b1;
                tx_byte_d  = tx_mem_q[tx_rp_q];
                tx_div_d   = cfg_div_s;
                tx_pen_d   = cfg_pen_s;
                tx_odd_d   = cfg_odd_s;
                tx_two_d   = cfg_two_s;
                pin_tx_d   = 1'b0;
            end else begin
                tx_state_d = TX_IDLE;
                pin_tx_d   = 1'b1;
            end
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= 3'd0;
            tx_byte_q  <= 8'd0;
            tx_div_q   <= DIV_W'(3);
            tx_pen_q   <= 1'b0;
            tx_odd_q   <= 1'b0;
            tx_two_q   <= 1'b0;
            pin_tx_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_div_q   <= tx_div_d;
            tx_pen_q   <= tx_pen_d;
            tx_odd_q   <= tx_odd_d;
            tx_two_q   <= tx_two_d;
            pin_tx_q   <= pin_tx_d;
        end
    end

    // RX next state: start validated at half-bit, then every sample lands one full bit later.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_baud_d    = rx_baud_q + DIV_W'(1);
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_div_d     = rx_div_q;
        rx_pen_d     = rx_pen_q;
        rx_odd_d     = rx_odd_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push_d    = 1'b0;
        ferr_set_s   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_baud_d = DIV_W'(0);
                if (rx_prev_q && !rx_s) begin
                    rx_state_d   = RX_START;
                    rx_div_d     = cfg_div_s;
                    rx_pen_d     = cfg_pen_s;
                    rx_odd_d     = cfg_odd_s;
                    rx_par_bad_d = 1'b0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_baud_q == (rx_div_q >> 1)) begin
                    rx_baud_d  = DIV_W'(0);
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_baud_q == rx_div_q) begin
                    rx_baud_d  = DIV_W'(0);
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_baud_q == rx_div_q) begin
                    rx_baud_d    = DIV_W'(0);
                    rx_par_bad_d = (rx_s != parity8(rx_shift_q, rx_odd_q));
                    rx_state_d   = RX_STOP;
                end else begin
                    rx_state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_baud_q == rx_div_q) begin
                    rx_baud_d  = DIV_W'(0);
                    rx_push_d  = rx_s;
                    ferr_set_s = !rx_s;
                    rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_WAIT_HIGH: begin
                rx_baud_d  = DIV_W'(0);
                rx_state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q    <= 3'b111;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_baud_q    <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            rx_div_q     <= DIV_W'(3);
            rx_pen_q     <= 1'b0;
            rx_odd_q     <= 1'b0;
            rx_par_bad_q <= 1'b0;
            rx_push_q    <= 1'b0;
        end else begin
            rx_sync_q    <= {rx_sync_q[1:0], pin_rx_i};
            rx_prev_q    <= rx_s;
            rx_state_q   <= rx_state_d;
            rx_baud_q    <= rx_baud_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_div_q     <= rx_div_d;
            rx_pen_q     <= rx_pen_d;
            rx_odd_q     <= rx_odd_d;
            rx_par_bad_q <= rx_par_bad_d;
            rx_push_q    <= rx_push_d;
        end
    end

    // Sticky flags: a set in the same cycle as clear_flags wins.
    always_comb begin
        tx_busy_s  = (tx_state_q != TX_IDLE);
        tx_empty_s = (tx_cnt_q == CW'(0));
        rx_avail_s = (rx_cnt_q != CW'(0));
        ovf_d      = ovf_set_s  | (ovf_q  & ~bus.clear_flags);
        perr_d     = par_set_s  | (perr_q & ~bus.clear_flags);
        ferr_d     = ferr_set_s | (ferr_q & ~bus.clear_flags);
        status_d   = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q), 1'b0, tx_empty_s, ferr_q, perr_q,
                      (tx_cnt_q == FULL_C), ovf_q, rx_avail_s, tx_busy_s};
        irq_d      = (bus.ctrl[19] & rx_avail_s) | (bus.ctrl[20] & tx_empty_s & ~tx_busy_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            status_q <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: TX waveform, loopback, vector table of RX frames, overflow, reset.
module tb_uart_fifo;
    localparam int DEPTH = 16;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       odd;
        logic       two;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pin_drv;
    logic loop_en;
    logic pin_rx;
    logic pin_tx;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb_q [$];
    vec_t vecs [6];

    uart_fifo_if bus();

    assign pin_rx = loop_en ? pin_tx : pin_drv;

    uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pin_rx_i (pin_rx),
        .pin_tx_o (pin_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_ctrl(input logic [15:0] div, input logic pen, input logic odd,
                                            input logic two, input logic irx, input logic itx);
        return {11'd0, itx, irx, two, odd, pen, div};
    endfunction

    task automatic send_frame(input vec_t v, input int div);
        logic q [$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(v.data[i]);
`ifdef UART_PARITY_EN
        if (v.pen) q.push_back((^v.data) ^ v.odd ^ v.bad_par);
`endif
        q.push_back(!v.bad_stop);
        if (v.two) q.push_back(1'b1);
        for (int i = 0; i < 3; i++) q.push_back(1'b1);
        foreach (q[i]) begin
            pin_drv = q[i];
            repeat (div + 1) @(negedge clk);
        end
    endtask

    task automatic read_byte(input string name);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: read with empty scoreboard", name);
        end else begin
            exp = sb_q.pop_front();
            check(name, {24'd0, bus.rx_data}, {24'd0, exp});
        end
        bus.rx_rd = 1'b1;
        @(negedge clk);
        bus.rx_rd = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_flags = 1'b1;
        @(negedge clk);
        bus.clear_flags = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [9:0] frame;
        int         mism [10];
        int         busy;
        vec_t       v;

        vecs[0] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef UART_PARITY_EN
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hB6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

        rst_n = 1'b0;
        pin_drv = 1'b1;
        loop_en = 1'b0;
        bus.ctrl = mk_ctrl(16'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.tx_data = 8'd0;
        bus.tx_wr = 1'b0;
        bus.rx_rd = 1'b0;
        bus.clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_status", bus.status, 32'd0);
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        check("reset_pin_tx", {31'd0, pin_tx}, 32'd1);
        check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 at divisor 9: exact bit timing, start latency and busy length
        frame = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) mism[b] = 0;
        busy = 0;
        bus.tx_data = 8'h55;
        bus.tx_wr = 1'b1;
        @(negedge clk);
        bus.tx_wr = 1'b0;
        check("tx_pin_before_start", {31'd0, pin_tx}, 32'd1);
        for (int s = 0; s < 110; s++) begin
            @(negedge clk);
            if (s == 0) check("tx_count_status", {24'd0, bus.status[23:16]}, 32'd1);
            if (s < 100) begin
                if (pin_tx !== frame[s / 10]) mism[s / 10]++;
            end
            if (s == 100) check("tx_pin_idle_after", {31'd0, pin_tx}, 32'd1);
            if (bus.status[0]) busy++;
        end
        for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_samples_wrong", b), mism[b], 32'd0);
        check("tx_busy_cycles", busy, 32'd100);
        check("tx_empty_after", {31'd0, bus.status[6]}, 32'd1);

        // Loopback of two back-to-back bytes
        loop_en = 1'b1;
        busy = 0;
        bus.tx_data = 8'hA5;
        bus.tx_wr = 1'b1;
        sb_q.push_back(8'hA5);
        @(negedge clk);
        bus.tx_data = 8'h3C;
        sb_q.push_back(8'h3C);
        @(negedge clk);
        bus.tx_wr = 1'b0;
        for (int s = 0; s < 240; s++) begin
            @(negedge clk);
            if (bus.status[0]) busy++;
        end
        check("lb_busy_no_gap", busy, 32'd200);
        check("lb_rx_count", {24'd0, bus.status[15:8]}, 32'd2);
        check("lb_flags", {29'd0, bus.status[5], bus.status[4], bus.status[2]}, 32'd0);
        bus.ctrl = mk_ctrl(16'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_rx_avail", {31'd0, bus.irq}, 32'd1);
        read_byte("lb_rx_data0");
        read_byte("lb_rx_data1");
        @(negedge clk);
        check("lb_rx_count_drained", {24'd0, bus.status[15:8]}, 32'd0);
        check("rx_data_empty", {24'd0, bus.rx_data}, 32'd0);
        check("irq_rx_cleared", {31'd0, bus.irq}, 32'd0);
        bus.ctrl = mk_ctrl(16'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("irq_tx_idle", {31'd0, bus.irq}, 32'd1);
        loop_en = 1'b0;

        // Table of received frames at divisor 5
        for (int i = 0; i < 6; i++) begin
            bus.ctrl = mk_ctrl(16'd5, vecs[i].pen, vecs[i].odd, vecs[i].two, 1'b0, 1'b0);
            if (vecs[i].exp_push) sb_q.push_back(vecs[i].data);
            send_frame(vecs[i], 5);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_rx_count", i), {24'd0, bus.status[15:8]}, vecs[i].exp_push ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_parity_err", i), {31'd0, bus.status[4]}, {31'd0, vecs[i].exp_perr});
            check($sformatf("vec%0d_framing_err", i), {31'd0, bus.status[5]}, {31'd0, vecs[i].exp_ferr});
            if (vecs[i].exp_push) read_byte($sformatf("vec%0d_rx_data", i));
            pulse_clear();
            check($sformatf("vec%0d_flags_cleared", i), {30'd0, bus.status[5:4]}, 32'd0);
        end

        // One-clock low glitch is a false start
        pin_drv = 1'b0;
        @(negedge clk);
        pin_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_byte", {24'd0, bus.status[15:8]}, 32'd0);

        // RX overflow with FIFO_DEPTH+1 frames at divisor 3
        bus.ctrl = mk_ctrl(16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            v = '{8'(i * 13 + 5), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            if (i < DEPTH) sb_q.push_back(v.data);
            send_frame(v, 3);
        end
        repeat (4) @(negedge clk);
        check("ovf_rx_count", {24'd0, bus.status[15:8]}, DEPTH);
        check("ovf_flag", {31'd0, bus.status[2]}, 32'd1);
        for (int i = 0; i < DEPTH; i++) read_byte($sformatf("ovf_rx_data%0d", i));
        repeat (2) @(negedge clk);
        check("ovf_drained", {24'd0, bus.status[15:8]}, 32'd0);
        pulse_clear();
        check("ovf_flag_cleared", {31'd0, bus.status[2]}, 32'd0);

        // TX FIFO fill, dropped extra write, then reset mid-frame
        bus.ctrl = mk_ctrl(16'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.tx_data = 8'h00;
        bus.tx_wr = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        bus.tx_wr = 1'b0;
        repeat (2) @(negedge clk);
        check("tx_full_count", {24'd0, bus.status[23:16]}, DEPTH);
        check("tx_full_flag", {31'd0, bus.status[3]}, 32'd1);
        check("tx_mid_frame_low", {31'd0, pin_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_pin_tx", {31'd0, pin_tx}, 32'd1);
        check("rst_status", bus.status, 32'd0);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
